// File: rtl/mby_igr_pkg.sv
// Shared types and constants for the ingress shim-to-Packet-Buffer path.
package mby_igr_pkg;

    localparam int SHIM_SEGS_PER_CYC = 3;
    localparam int SHIM_NUM_PORTS    = 4;
    localparam int SEG_W             = 512;

    typedef struct packed {
        logic [SEG_W-1:0] data;
    } shim_pb_seg_t;

    typedef struct packed {
        shim_pb_seg_t [0:SHIM_SEGS_PER_CYC-1] seg;
    } shim_pb_data_t;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/igr_shim_pb_sched_if.sv
// Packet Buffer write-port handshake: o_pb_v/o_pb_seg/o_pb_port travel with
// a valid/ready rule -- a segment transfers on a clock edge where o_pb_v and
// i_pb_rdy are both high, and the master holds the payload stable until then.
interface igr_shim_pb_sched_if;
    import mby_igr_pkg::*;

    logic         o_pb_v;
    shim_pb_seg_t o_pb_seg;
    logic [1:0]   o_pb_port;
    logic         i_pb_rdy;

    modport master (output o_pb_v, output o_pb_seg, output o_pb_port, input i_pb_rdy);
    modport slave  (input o_pb_v, input o_pb_seg, input o_pb_port, output i_pb_rdy);
endinterface

// File: rtl/igr_shim_seg_fifo.sv
// Per-port segment FIFO: 3-wide packed all-or-nothing write, 1-wide read.
// Drop counter present only with IGR_SHIM_PB_SCHED_STATS_EN.
module igr_shim_seg_fifo
    import mby_igr_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           cclk,
    input  logic           rst,
    input  shim_pb_data_t  i_data,
    input  logic [2:0]     i_v,
    input  logic           i_pop,
    output shim_pb_seg_t   o_head,
    output logic [PTR_W:0] o_cnt,
    output logic           o_ovf
`ifdef IGR_SHIM_PB_SCHED_STATS_EN
    ,
    output logic [15:0]    o_drop_cnt
`endif
);
    localparam int FW = PTR_W + 2;
    localparam int CW = PTR_W + 1;

    shim_pb_seg_t     mem_q [DEPTH];
    shim_pb_seg_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       k;
    logic [FW-1:0]    free;
    logic             accept;
    logic [1:0]       off [SHIM_SEGS_PER_CYC];

    // Room includes the slot freed by a same-cycle pop; pushed data lands
    // behind the head, so it is never the entry popped this cycle.
    always_comb begin
        k        = popcnt3(i_v);
        free     = FW'(DEPTH) - FW'(cnt_q) + FW'(i_pop);
        accept   = FW'(k) <= free;
        off[0]   = 2'd0;
        off[1]   = {1'b0, i_v[0]};
        off[2]   = {1'b0, i_v[0]} + {1'b0, i_v[1]};
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(i_pop);
        cnt_d    = cnt_q - CW'(i_pop);
        ovf_d    = ovf_q;
        if (accept) begin
            for (int j = 0; j < SHIM_SEGS_PER_CYC; j++) begin
                if (i_v[j]) mem_d[wr_ptr_q + PTR_W'(off[j])] = i_data.seg[j];
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(k);
            cnt_d    = cnt_q + CW'(k) - CW'(i_pop);
        end else begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: an entry is only read once the count covers it.
    always_ff @(posedge cclk) begin
        mem_q <= mem_d;
    end

    assign o_head = mem_q[rd_ptr_q];
    assign o_cnt  = cnt_q;
    assign o_ovf  = ovf_q;

`ifdef IGR_SHIM_PB_SCHED_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 17'(k);
        drop_cnt_d = drop_cnt_q;
        if (!accept) drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`endif
endmodule

// File: rtl/igr_shim_pb_sched.sv
// Four shim ports -> per-port FIFOs -> round-robin -> one registered PB output.
// IGR_SHIM_PB_SCHED_STATS_EN adds per-port 16-bit saturating drop counters.
module igr_shim_pb_sched
    import mby_igr_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                       cclk,
    input  logic                       rst,
    input  shim_pb_data_t              i_shim_pb_data_p0,
    input  shim_pb_data_t              i_shim_pb_data_p1,
    input  shim_pb_data_t              i_shim_pb_data_p2,
    input  shim_pb_data_t              i_shim_pb_data_p3,
    input  logic [2:0]                 i_shim_pb_v_p0,
    input  logic [2:0]                 i_shim_pb_v_p1,
    input  logic [2:0]                 i_shim_pb_v_p2,
    input  logic [2:0]                 i_shim_pb_v_p3,
    igr_shim_pb_sched_if.master        pb,
    output logic [SHIM_NUM_PORTS-1:0]  o_ovf,
    output logic [PTR_W:0]             o_fifo_cnt_p0,
    output logic [PTR_W:0]             o_fifo_cnt_p1,
    output logic [PTR_W:0]             o_fifo_cnt_p2,
    output logic [PTR_W:0]             o_fifo_cnt_p3
`ifdef IGR_SHIM_PB_SCHED_STATS_EN
    ,
    output logic [15:0]                o_drop_cnt_p0,
    output logic [15:0]                o_drop_cnt_p1,
    output logic [15:0]                o_drop_cnt_p2,
    output logic [15:0]                o_drop_cnt_p3
`endif
);
    shim_pb_data_t             data_a [SHIM_NUM_PORTS];
    logic [2:0]                v_a    [SHIM_NUM_PORTS];
    shim_pb_seg_t              head   [SHIM_NUM_PORTS];
    logic [PTR_W:0]            cnt    [SHIM_NUM_PORTS];
    logic [SHIM_NUM_PORTS-1:0] pop;

    assign data_a = '{i_shim_pb_data_p0, i_shim_pb_data_p1, i_shim_pb_data_p2, i_shim_pb_data_p3};
    assign v_a    = '{i_shim_pb_v_p0, i_shim_pb_v_p1, i_shim_pb_v_p2, i_shim_pb_v_p3};

`ifdef IGR_SHIM_PB_SCHED_STATS_EN
    logic [15:0] drop_a [SHIM_NUM_PORTS];
    assign o_drop_cnt_p0 = drop_a[0];
    assign o_drop_cnt_p1 = drop_a[1];
    assign o_drop_cnt_p2 = drop_a[2];
    assign o_drop_cnt_p3 = drop_a[3];
`endif

    for (genvar p = 0; p < SHIM_NUM_PORTS; p++) begin : g_port
        igr_shim_seg_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
            .cclk   (cclk),
            .rst    (rst),
            .i_data (data_a[p]),
            .i_v    (v_a[p]),
            .i_pop  (pop[p]),
            .o_head (head[p]),
            .o_cnt  (cnt[p]),
            .o_ovf  (o_ovf[p])
`ifdef IGR_SHIM_PB_SCHED_STATS_EN
            ,
            .o_drop_cnt (drop_a[p])
`endif
        );
    end

    assign o_fifo_cnt_p0 = cnt[0];
    assign o_fifo_cnt_p1 = cnt[1];
    assign o_fifo_cnt_p2 = cnt[2];
    assign o_fifo_cnt_p3 = cnt[3];

    logic         pb_v_q, pb_v_d;
    shim_pb_seg_t seg_q, seg_d;
    logic [1:0]   port_q, port_d;
    logic [1:0]   last_grant_q, last_grant_d;
    logic         load, grant_v;
    logic [1:0]   sel, idx;

    // Search starts one past the last grant; i == 4 wraps back to it last.
    always_comb begin
        load         = !pb_v_q || pb.i_pb_rdy;
        grant_v      = 1'b0;
        sel          = last_grant_q;
        idx          = '0;
        pb_v_d       = pb_v_q;
        seg_d        = seg_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        pop          = '0;
        for (int i = 1; i <= SHIM_NUM_PORTS; i++) begin
            idx = last_grant_q + 2'(i);
            if (!grant_v && cnt[idx] != '0) begin
                grant_v = 1'b1;
                sel     = idx;
            end
        end
        if (load) begin
            pb_v_d = grant_v;
            if (grant_v) begin
                seg_d        = head[sel];
                port_d       = sel;
                last_grant_d = sel;
                pop[sel]     = 1'b1;
            end
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            pb_v_q       <= 1'b0;
            seg_q        <= '0;
            port_q       <= '0;
            last_grant_q <= 2'd3;
        end else begin
            pb_v_q       <= pb_v_d;
            seg_q        <= seg_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign pb.o_pb_v    = pb_v_q;
    assign pb.o_pb_seg  = seg_q;
    assign pb.o_pb_port = port_q;
endmodule

// File: tb/tb_igr_shim_pb_sched.sv
// Directed bench for igr_shim_pb_sched with an expected-segment scoreboard.
module tb_igr_shim_pb_sched;
  import mby_igr_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int EW    = 2 + SEG_W;

  logic           cclk = 1'b0;
  logic           rst;
  shim_pb_data_t  d_p   [4];
  logic [2:0]     v_p   [4];
  logic [3:0]     ovf;
  logic [PTR_W:0] cnt_p [4];
`ifdef IGR_SHIM_PB_SCHED_STATS_EN
  logic [15:0]    drop_p [4];
`endif

  igr_shim_pb_sched_if pb_if ();

  igr_shim_pb_sched #(.DEPTH(DEPTH)) dut (
    .cclk              (cclk),
    .rst               (rst),
    .i_shim_pb_data_p0 (d_p[0]),
    .i_shim_pb_data_p1 (d_p[1]),
    .i_shim_pb_data_p2 (d_p[2]),
    .i_shim_pb_data_p3 (d_p[3]),
    .i_shim_pb_v_p0    (v_p[0]),
    .i_shim_pb_v_p1    (v_p[1]),
    .i_shim_pb_v_p2    (v_p[2]),
    .i_shim_pb_v_p3    (v_p[3]),
    .pb                (pb_if),
    .o_ovf             (ovf),
    .o_fifo_cnt_p0     (cnt_p[0]),
    .o_fifo_cnt_p1     (cnt_p[1]),
    .o_fifo_cnt_p2     (cnt_p[2]),
    .o_fifo_cnt_p3     (cnt_p[3])
`ifdef IGR_SHIM_PB_SCHED_STATS_EN
    ,
    .o_drop_cnt_p0     (drop_p[0]),
    .o_drop_cnt_p1     (drop_p[1]),
    .o_drop_cnt_p2     (drop_p[2]),
    .o_drop_cnt_p3     (drop_p[3])
`endif
  );

  // clock / reset
  always #5 cclk = ~cclk;

  // scoreboard state
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] exp_e;
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  function automatic shim_pb_seg_t mk_seg(input logic [31:0] id);
    shim_pb_seg_t s;
    s.data = {16{id}};
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic clear_in();
    for (int p = 0; p < 4; p++) begin
      v_p[p] = 3'b000;
      d_p[p] = '0;
    end
  endtask

  task automatic set_port(input int p, input logic [2:0] v, input logic [31:0] id0,
                          input logic [31:0] id1, input logic [31:0] id2);
    v_p[p] = v;
    d_p[p].seg[0] = mk_seg(id0);
    d_p[p].seg[1] = mk_seg(id1);
    d_p[p].seg[2] = mk_seg(id2);
  endtask

  task automatic push_exp(input logic [1:0] port, input logic [31:0] id);
    exp_q.push_back({port, mk_seg(id)});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !pb_if.o_pb_v) break;
      tick();
    end
    check(name, 64'(exp_q.size() == 0 && !pb_if.o_pb_v), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pb_if.i_pb_rdy = 1'b0;
    clear_in();

    // monitor: pops and compares whenever a segment transfers
    fork
      forever begin
        @(negedge cclk);
        if (!rst && pb_if.o_pb_v && pb_if.i_pb_rdy) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL mon_unexpected: got port %0d seg %h expected none",
                     pb_if.o_pb_port, pb_if.o_pb_seg.data[31:0]);
          end else begin
            exp_e = exp_q.pop_front();
            if ({pb_if.o_pb_port, pb_if.o_pb_seg} === exp_e) pass_cnt++;
            else $display("FAIL mon_seg: got port %0d seg %h expected port %0d seg %h",
                          pb_if.o_pb_port, pb_if.o_pb_seg.data[31:0],
                          exp_e[EW-1 -: 2], exp_e[31:0]);
          end
        end
      end
    join_none

    tick(); tick();
    check("rst_v", 64'(pb_if.o_pb_v), 64'd0);
    check("rst_port", 64'(pb_if.o_pb_port), 64'd0);
    check("rst_seg", 64'(|pb_if.o_pb_seg), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    for (int p = 0; p < 4; p++) check("rst_cnt", 64'(cnt_p[p]), 64'd0);
    rst = 1'b0;
    tick();

    // single segment on port 2
    pb_if.i_pb_rdy = 1'b1;
    set_port(2, 3'b001, 32'h21, 32'h22, 32'h23);
    push_exp(2, 32'h21);
    tick();
    clear_in();
    check("t1_v_early", 64'(pb_if.o_pb_v), 64'd0);
    check("t1_cnt2_push", 64'(cnt_p[2]), 64'd1);
    tick();
    check("t1_v", 64'(pb_if.o_pb_v), 64'd1);
    check("t1_port", 64'(pb_if.o_pb_port), 64'd2);
    check("t1_cnt2_pop", 64'(cnt_p[2]), 64'd0);
    tick();
    check("t1_pulse_end", 64'(pb_if.o_pb_v), 64'd0);
    wait_drain("t1_drain");

    // packing order: seg0 then seg2
    set_port(0, 3'b101, 32'h0A, 32'h0B, 32'h0C);
    push_exp(0, 32'h0A);
    push_exp(0, 32'h0C);
    tick();
    clear_in();
    check("t2_cnt0", 64'(cnt_p[0]), 64'd2);
    tick();
    check("t2_v_first", 64'(pb_if.o_pb_v), 64'd1);
    tick();
    check("t2_v_second", 64'(pb_if.o_pb_v), 64'd1);
    check("t2_port", 64'(pb_if.o_pb_port), 64'd0);
    wait_drain("t2_drain");

    // fairness from reset priority
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) set_port(p, 3'b011, 32'h30 + 32'(p * 16), 32'h31 + 32'(p * 16), 32'h0);
    for (int j = 0; j < 2; j++)
      for (int p = 0; p < 4; p++) push_exp(2'(p), 32'h30 + 32'(p * 16) + 32'(j));
    tick();
    clear_in();
    for (int p = 0; p < 4; p++) check("t3_cnt", 64'(cnt_p[p]), 64'd2);
    wait_drain("t3_drain");

    // backpressure
    pb_if.i_pb_rdy = 1'b0;
    set_port(3, 3'b111, 32'h41, 32'h42, 32'h43);
    push_exp(3, 32'h41);
    push_exp(3, 32'h42);
    push_exp(3, 32'h43);
    tick();
    clear_in();
    check("t4_cnt3_push", 64'(cnt_p[3]), 64'd3);
    tick();
    check("t4_v", 64'(pb_if.o_pb_v), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_v", 64'(pb_if.o_pb_v), 64'd1);
      check("t4_hold_seg", 64'(pb_if.o_pb_seg === mk_seg(32'h41)), 64'd1);
      check("t4_hold_cnt3", 64'(cnt_p[3]), 64'd2);
    end
    pb_if.i_pb_rdy = 1'b1;
    tick();
    check("t4_next_seg", 64'(pb_if.o_pb_seg === mk_seg(32'h42)), 64'd1);
    check("t4_cnt3_after", 64'(cnt_p[3]), 64'd1);
    wait_drain("t4_drain");

    // overflow, exact fit and full drop on port 1 behind a stalled output
    pb_if.i_pb_rdy = 1'b0;
    set_port(0, 3'b001, 32'h50, 32'h0, 32'h0);
    push_exp(0, 32'h50);
    tick();
    clear_in();
    set_port(1, 3'b111, 32'h51, 32'h52, 32'h53);
    for (int i = 0; i < 3; i++) push_exp(1, 32'h51 + 32'(i));
    tick();
    check("t5_v", 64'(pb_if.o_pb_v), 64'd1);
    check("t5_cnt1_a", 64'(cnt_p[1]), 64'd3);
    set_port(1, 3'b111, 32'h54, 32'h55, 32'h56);
    for (int i = 0; i < 3; i++) push_exp(1, 32'h54 + 32'(i));
    tick();
    check("t5_cnt1_b", 64'(cnt_p[1]), 64'd6);
    check("t5_ovf_none", 64'(ovf), 64'd0);
    set_port(1, 3'b111, 32'h57, 32'h58, 32'h59);
    tick();
    check("t5_cnt1_drop", 64'(cnt_p[1]), 64'd6);
    check("t5_ovf", 64'(ovf), 64'b0010);
`ifdef IGR_SHIM_PB_SCHED_STATS_EN
    check("t5_drop_cnt1", 64'(drop_p[1]), 64'd3);
`endif
    set_port(1, 3'b011, 32'h5A, 32'h5B, 32'h0);
    push_exp(1, 32'h5A);
    push_exp(1, 32'h5B);
    tick();
    check("t5_cnt1_fit", 64'(cnt_p[1]), 64'd8);
    set_port(1, 3'b100, 32'h0, 32'h0, 32'h5C);
    tick();
    clear_in();
    check("t5_cnt1_full", 64'(cnt_p[1]), 64'd8);
    check("t5_ovf_sticky", 64'(ovf), 64'b0010);
    check("t5_hold_seg", 64'(pb_if.o_pb_seg === mk_seg(32'h50)), 64'd1);
`ifdef IGR_SHIM_PB_SCHED_STATS_EN
    check("t5_drop_cnt1_full", 64'(drop_p[1]), 64'd4);
`endif
    pb_if.i_pb_rdy = 1'b1;
    wait_drain("t5_drain");

    // reset mid-stream
    pb_if.i_pb_rdy = 1'b0;
    set_port(2, 3'b111, 32'h61, 32'h62, 32'h63);
    set_port(3, 3'b011, 32'h64, 32'h65, 32'h0);
    tick();
    clear_in();
    tick();
    check("t6_pre_v", 64'(pb_if.o_pb_v), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_v", 64'(pb_if.o_pb_v), 64'd0);
    tick();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) check("t6_cnt", 64'(cnt_p[p]), 64'd0);
    check("t6_ovf", 64'(ovf), 64'd0);
    pb_if.i_pb_rdy = 1'b1;
    set_port(3, 3'b001, 32'h71, 32'h0, 32'h0);
    set_port(0, 3'b001, 32'h70, 32'h0, 32'h0);
    push_exp(0, 32'h70);
    push_exp(3, 32'h71);
    tick();
    clear_in();
    tick();
    check("t6_first_port", 64'(pb_if.o_pb_port), 64'd0);
    check("t6_first_v", 64'(pb_if.o_pb_v), 64'd1);
    wait_drain("t6_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
